// File: rtl/vrf_read_pipe_if.sv
// vrf_read_pipe_if
//   Groups the request and response handshakes of the VRF read pipeline.
//   Request side : req_valid/req_ready plus vs, readSource, offset and
//                  instructionIndex payload fields.
//   Response side: resp_valid/resp_ready plus data, readSource and
//                  instructionIndex of the original request.
//   Modports:
//     master - the requester/consumer side (drives requests, accepts responses)
//     slave  - the pipeline itself (accepts requests, drives responses)
interface vrf_read_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_ready;
    logic                  req_valid;
    logic [4:0]            req_bits_vs;
    logic [1:0]            req_bits_readSource;
    logic [5:0]            req_bits_offset;
    logic [2:0]            req_bits_instructionIndex;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_bits_data;
    logic [1:0]            resp_bits_readSource;
    logic [2:0]            resp_bits_instructionIndex;

    modport master (
        input  req_ready,
        output req_valid,
        output req_bits_vs,
        output req_bits_readSource,
        output req_bits_offset,
        output req_bits_instructionIndex,
        input  resp_valid,
        output resp_ready,
        input  resp_bits_data,
        input  resp_bits_readSource,
        input  resp_bits_instructionIndex
    );

    modport slave (
        output req_ready,
        input  req_valid,
        input  req_bits_vs,
        input  req_bits_readSource,
        input  req_bits_offset,
        input  req_bits_instructionIndex,
        output resp_valid,
        input  resp_ready,
        output resp_bits_data,
        output resp_bits_readSource,
        output resp_bits_instructionIndex
    );
endinterface

// File: rtl/vrf_read_pipe.sv
// vrf_read_pipe
//   Single-bank VRF read stage. Accepts one arbitrated read per cycle, strobes
//   the bank SRAM, carries the request tags alongside the fixed SRAM latency
//   and parks data+tags in a credit-guarded response FIFO so a stalled
//   consumer never loses an in-flight read.
//   Ports:
//     clock, reset     - rising-edge clock, asynchronous active-high reset
//     bus (slave)      - request/response handshakes, see vrf_read_pipe_if
//     sram_write_busy  - write port owns the SRAM this cycle (blocks reads)
//     sram_read_en     - SRAM read strobe (equals request fire)
//     sram_addr        - {vs, offset}
//     sram_read_data   - valid READ_LATENCY cycles after the strobe
//     idle             - nothing in flight and response FIFO empty
module vrf_read_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    vrf_read_pipe_if.slave        bus,
    input  logic                  sram_write_busy,
    output logic                  sram_read_en,
    output logic [10:0]           sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_read_data,
    output logic                  idle
);
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int CRED_W = $clog2(RESP_DEPTH + READ_LATENCY + 1) + 1;
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(RESP_DEPTH - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(RESP_DEPTH);
    localparam logic [CRED_W-1:0] DEPTH_CRED = CRED_W'(RESP_DEPTH);

    logic [READ_LATENCY-1:0] stage_valid_q, stage_valid_d;
    logic [1:0]              stage_src_q [READ_LATENCY];
    logic [1:0]              stage_src_d [READ_LATENCY];
    logic [2:0]              stage_idx_q [READ_LATENCY];
    logic [2:0]              stage_idx_d [READ_LATENCY];

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q [RESP_DEPTH];
    logic [1:0]              fifo_src_q  [RESP_DEPTH];
    logic [2:0]              fifo_idx_q  [RESP_DEPTH];

    logic [CRED_W-1:0]       inflight;
    logic                    req_ready;
    logic                    fire;
    logic                    enq;
    logic                    deq;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Credit check uses the registered FIFO count only, so a same-cycle
    // dequeue never feeds back combinationally from resp_ready to req_ready.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CRED_W'(stage_valid_q[i]);
        end
        req_ready = !reset && !sram_write_busy
                    && ((inflight + CRED_W'(count_q)) < DEPTH_CRED);
    end

    assign fire          = bus.req_valid && req_ready;
    assign bus.req_ready = req_ready;
    assign sram_read_en  = fire;
    assign sram_addr     = {bus.req_bits_vs, bus.req_bits_offset};
    assign enq           = stage_valid_q[READ_LATENCY-1];
    assign deq           = (count_q != '0) && bus.resp_ready;

    // Tag pipeline shifts every cycle because the SRAM itself cannot stall;
    // payload is loaded unconditionally and qualified by the valid bit.
    always_comb begin
        stage_valid_d[0] = fire;
        stage_src_d[0]   = bus.req_bits_readSource;
        stage_idx_d[0]   = bus.req_bits_instructionIndex;
        for (int i = 1; i < READ_LATENCY; i++) begin
            stage_valid_d[i] = stage_valid_q[i-1];
            stage_src_d[i]   = stage_src_q[i-1];
            stage_idx_d[i]   = stage_idx_q[i-1];
        end
    end

    always_comb begin
        wr_ptr_d = enq ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_valid_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_src_q[i] <= '0;
                stage_idx_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_src_q[i] <= stage_src_d[i];
                stage_idx_q[i] <= stage_idx_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observable through count_q.
    always_ff @(posedge clock) begin
        if (enq) begin
            fifo_data_q[wr_ptr_q] <= sram_read_data;
            fifo_src_q[wr_ptr_q]  <= stage_src_q[READ_LATENCY-1];
            fifo_idx_q[wr_ptr_q]  <= stage_idx_q[READ_LATENCY-1];
        end
    end

    assign bus.resp_valid                 = (count_q != '0);
    assign bus.resp_bits_data             = fifo_data_q[rd_ptr_q];
    assign bus.resp_bits_readSource       = fifo_src_q[rd_ptr_q];
    assign bus.resp_bits_instructionIndex = fifo_idx_q[rd_ptr_q];
    assign idle = (inflight == '0) && (count_q == '0);

    // The credit rule must make a full-FIFO enqueue impossible.
    fifo_no_overflow: assert property (
        @(posedge clock) disable iff (reset) !(enq && (count_q == DEPTH_CNT))
    );
endmodule

// File: tb/tb_vrf_read_pipe.sv
// tb_vrf_read_pipe
//   Directed bench for vrf_read_pipe: a table of per-cycle vectors for the
//   single-read and full-backpressure cases, plus hand-written sequences for
//   streaming, write conflicts, pointer wrap-around and reset mid-flight.
//   A two-stage SRAM model returns a word derived from the address, and a
//   scoreboard built from the requests checks every response in order.
module tb_vrf_read_pipe;
    logic        clock = 1'b0;
    logic        reset;
    logic        sram_write_busy;
    logic        sram_read_en;
    logic [10:0] sram_addr;
    logic [31:0] sram_read_data;
    logic        idle;

    int n_compared   = 0;
    int n_mismatched = 0;
    int deq_count    = 0;
    int tag_seq      = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  src;
        logic [2:0]  idx;
    } resp_t;
    resp_t sb[$];

    typedef struct {
        logic        rv;
        logic [4:0]  vs;
        logic [1:0]  src;
        logic [5:0]  off;
        logic [2:0]  idx;
        logic        rr;
        logic        e_ready;
        logic        e_en;
        logic [10:0] e_addr;
        logic        e_resp_valid;
        logic        e_idle;
    } vec_t;
    vec_t vecs[$];

    always #5 clock = ~clock;

    vrf_read_pipe_if #(.DATA_WIDTH(32)) bus_if ();

    vrf_read_pipe #(
        .DATA_WIDTH  (32),
        .READ_LATENCY(2),
        .RESP_DEPTH  (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus_if),
        .sram_write_busy(sram_write_busy),
        .sram_read_en   (sram_read_en),
        .sram_addr      (sram_addr),
        .sram_read_data (sram_read_data),
        .idle           (idle)
    );

    function automatic logic [31:0] sram_word(input logic [10:0] a);
        return {a, 5'h00, ~a, 5'h15};
    endfunction

    // Bank SRAM model with a fixed two-cycle read latency; junk otherwise.
    logic [1:0]  rd_v = 2'b00;
    logic [10:0] rd_a0, rd_a1;
    always @(posedge clock) begin
        rd_v  <= {rd_v[0], sram_read_en};
        rd_a0 <= sram_addr;
        rd_a1 <= rd_a0;
    end
    assign sram_read_data = rd_v[1] ? sram_word(rd_a1) : 32'hBAD0_BAD0;

    function automatic vec_t mk(input logic rv, input logic [4:0] vs,
                                input logic [1:0] src, input logic [5:0] off,
                                input logic [2:0] idx, input logic rr,
                                input logic e_ready, input logic e_en,
                                input logic [10:0] e_addr,
                                input logic e_rv, input logic e_idle);
        vec_t v;
        v.rv = rv; v.vs = vs; v.src = src; v.off = off; v.idx = idx; v.rr = rr;
        v.e_ready = e_ready; v.e_en = e_en; v.e_addr = e_addr;
        v.e_resp_valid = e_rv; v.e_idle = e_idle;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Records accepted requests and checks any response taken this cycle.
    task automatic score();
        resp_t e;
        if (bus_if.req_valid && bus_if.req_ready) begin
            e.data = sram_word({bus_if.req_bits_vs, bus_if.req_bits_offset});
            e.src  = bus_if.req_bits_readSource;
            e.idx  = bus_if.req_bits_instructionIndex;
            sb.push_back(e);
        end
        if (bus_if.resp_valid && bus_if.resp_ready) begin
            deq_count++;
            if (sb.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL resp_unexpected: got data 0x%0h, expected no response",
                         bus_if.resp_bits_data);
            end else begin
                e = sb.pop_front();
                check_output("resp_data", bus_if.resp_bits_data, e.data);
                check_output("resp_src", 32'(bus_if.resp_bits_readSource), 32'(e.src));
                check_output("resp_idx", 32'(bus_if.resp_bits_instructionIndex), 32'(e.idx));
            end
        end
    endtask

    // One clock cycle: drive inputs just after the edge, then sample.
    task automatic apply_stimulus(input logic rv, input logic [4:0] vs,
                                  input logic [1:0] src, input logic [5:0] off,
                                  input logic [2:0] idx, input logic wb,
                                  input logic rr);
        @(posedge clock);
        #1;
        bus_if.req_valid                 = rv;
        bus_if.req_bits_vs               = vs;
        bus_if.req_bits_readSource       = src;
        bus_if.req_bits_offset           = off;
        bus_if.req_bits_instructionIndex = idx;
        bus_if.resp_ready                = rr;
        sram_write_busy                  = wb;
        #1;
        score();
    endtask

    task automatic send_burst(input int n);
        int sent  = 0;
        int guard = 0;
        while (sent < n && guard < 60) begin
            apply_stimulus(1'b1, 5'(tag_seq * 7 + 3), 2'(tag_seq), 6'(tag_seq * 13 + 1),
                           3'(tag_seq + 5), 1'b0, 1'b0);
            if (bus_if.req_ready) begin
                sent++;
                tag_seq++;
            end
            guard++;
        end
        check_output("send_accepted", 32'(sent), 32'(n));
    endtask

    task automatic drain(input int n);
        int start = deq_count;
        int guard = 0;
        while ((deq_count - start) < n && guard < 60) begin
            apply_stimulus(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b0, 1'b1);
            guard++;
        end
        check_output("drain_dequeued", 32'(deq_count - start), 32'(n));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Single read: fire at row 0, response visible at row 3, idle at row 4.
        vecs.push_back(mk(1'b1, 5'd3, 2'd2, 6'd5, 3'd6, 1'b1, 1'b1, 1'b1, 11'h0C5, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b1, 1'b1, 1'b0, 11'h000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b1, 1'b1, 1'b0, 11'h000, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b1, 1'b1, 1'b0, 11'h000, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b1, 1'b1, 1'b0, 11'h000, 1'b0, 1'b1));
        // Full backpressure: four accepted, blocked until one dequeue.
        vecs.push_back(mk(1'b1, 5'd1, 2'd0, 6'd1, 3'd1, 1'b0, 1'b1, 1'b1, 11'h041, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 5'd2, 2'd1, 6'd2, 3'd2, 1'b0, 1'b1, 1'b1, 11'h082, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 5'd4, 2'd2, 6'd4, 3'd3, 1'b0, 1'b1, 1'b1, 11'h104, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 5'd8, 2'd3, 6'd8, 3'd4, 1'b0, 1'b1, 1'b1, 11'h208, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'd9, 2'd0, 6'd9, 3'd5, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'd9, 2'd0, 6'd9, 3'd5, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'd9, 2'd0, 6'd9, 3'd5, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'd9, 2'd0, 6'd9, 3'd5, 1'b1, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 5'd9, 2'd0, 6'd9, 3'd5, 1'b0, 1'b1, 1'b1, 11'h249, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b1, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b1, 1'b1, 1'b0, 11'h000, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b1, 1'b1, 1'b0, 11'h000, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b1, 1'b1, 1'b0, 11'h000, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b1, 1'b1, 1'b0, 11'h000, 1'b0, 1'b1));

        // Reset state, with a request pending to show it is not accepted.
        reset                            = 1'b1;
        sram_write_busy                  = 1'b0;
        bus_if.req_valid                 = 1'b1;
        bus_if.req_bits_vs               = 5'd0;
        bus_if.req_bits_readSource       = 2'd0;
        bus_if.req_bits_offset           = 6'd0;
        bus_if.req_bits_instructionIndex = 3'd0;
        bus_if.resp_ready                = 1'b0;
        #2;
        check_output("rst_req_ready", 32'(bus_if.req_ready), 32'd0);
        check_output("rst_sram_read_en", 32'(sram_read_en), 32'd0);
        check_output("rst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check_output("rst_idle", 32'(idle), 32'd1);
        @(posedge clock);
        #1;
        reset            = 1'b0;
        bus_if.req_valid = 1'b0;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rv, vecs[i].vs, vecs[i].src, vecs[i].off,
                           vecs[i].idx, 1'b0, vecs[i].rr);
            check_output($sformatf("vec%0d_req_ready", i), 32'(bus_if.req_ready), 32'(vecs[i].e_ready));
            check_output($sformatf("vec%0d_sram_read_en", i), 32'(sram_read_en), 32'(vecs[i].e_en));
            if (vecs[i].e_en)
                check_output($sformatf("vec%0d_sram_addr", i), 32'(sram_addr), 32'(vecs[i].e_addr));
            check_output($sformatf("vec%0d_resp_valid", i), 32'(bus_if.resp_valid), 32'(vecs[i].e_resp_valid));
            check_output($sformatf("vec%0d_idle", i), 32'(idle), 32'(vecs[i].e_idle));
        end

        // Streaming: 16 back-to-back requests, responses in cycles 3..18.
        for (int i = 0; i < 19; i++) begin
            if (i < 16) begin
                apply_stimulus(1'b1, 5'(i + 1), 2'(i), 6'(i * 3), 3'(i), 1'b0, 1'b1);
                check_output($sformatf("stream_req_ready_c%0d", i), 32'(bus_if.req_ready), 32'd1);
            end else begin
                apply_stimulus(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b0, 1'b1);
            end
            check_output($sformatf("stream_resp_valid_c%0d", i), 32'(bus_if.resp_valid),
                         (i >= 3) ? 32'd1 : 32'd0);
        end
        apply_stimulus(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b0, 1'b1);
        check_output("stream_idle_after", 32'(idle), 32'd1);

        // Write conflict: busy in cycles 2 and 5 blocks those fires only.
        for (int i = 0; i < 10; i++) begin
            logic wb;
            wb = (i == 2) || (i == 5);
            apply_stimulus(1'b1, 5'(20 + i), 2'(i + 1), 6'(40 + i), 3'(7 - i), wb, 1'b1);
            check_output($sformatf("wbusy_read_en_c%0d", i), 32'(sram_read_en), 32'(!wb));
            check_output($sformatf("wbusy_req_ready_c%0d", i), 32'(bus_if.req_ready), 32'(!wb));
        end
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b0, 1'b1);
        end
        check_output("wbusy_idle_after", 32'(idle), 32'd1);
        check_output("wbusy_sb_empty", 32'(sb.size()), 32'd0);

        // Wrap-around: 4 + 3 + 4 requests with partial drains in between.
        send_burst(4);
        drain(3);
        send_burst(3);
        drain(4);
        send_burst(4);
        drain(4);
        check_output("wrap_sb_empty", 32'(sb.size()), 32'd0);

        // Reset with reads still in flight and entries queued.
        send_burst(4);
        @(posedge clock);
        #1;
        bus_if.req_valid = 1'b1;
        reset            = 1'b1;
        #1;
        check_output("midrst_resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check_output("midrst_idle", 32'(idle), 32'd1);
        check_output("midrst_req_ready", 32'(bus_if.req_ready), 32'd0);
        check_output("midrst_read_en", 32'(sram_read_en), 32'd0);
        @(posedge clock);
        #1;
        reset            = 1'b0;
        bus_if.req_valid = 1'b0;
        sb.delete();
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(1'b0, 5'd0, 2'd0, 6'd0, 3'd0, 1'b0, 1'b1);
            check_output($sformatf("postrst_resp_valid_c%0d", i), 32'(bus_if.resp_valid), 32'd0);
            check_output($sformatf("postrst_idle_c%0d", i), 32'(idle), 32'd1);
            check_output($sformatf("postrst_req_ready_c%0d", i), 32'(bus_if.req_ready), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
